ram_port_arbiter: RTL and testbench

- Shares the single-port 256x16 datapath RAM (myRAM1: address, clock, data, wren, q) between two requesters.
- Requester 0 is the datapath load/store unit; requester 1 is a secondary master (loader/debug).
- Per-requester request/grant handshake, one accepted access per cycle, round-robin arbitration on conflict.
- Read data is returned to the requester that issued the read, tagged by a valid strobe that accounts for RAM latency.

---
 rtl/ram_port_arbiter_if.sv | 45 ++++
 rtl/ram_port_arbiter.sv | 96 +++++++++
 tb/tb_ram_port_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_port_arbiter_if.sv
// Bus bundle between two RAM requesters, the arbiter and the single-port RAM.
// The slave modport is the arbiter's view; master is the environment's view.
interface ram_port_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 16
);
    logic          Req0;
    logic          We0;
    logic [AW-1:0] Addr0;
    logic [DW-1:0] Wdata0;
    logic          Gnt0;
    logic          Rvalid0;
    logic [DW-1:0] Rdata0;

    logic          Req1;
    logic          We1;
    logic [AW-1:0] Addr1;
    logic [DW-1:0] Wdata1;
    logic          Gnt1;
    logic          Rvalid1;
    logic [DW-1:0] Rdata1;

    logic [AW-1:0] RamAddr;
    logic [DW-1:0] RamData;
    logic          RamWren;
    logic [DW-1:0] RamQ;

    modport slave (
        input  Req0, We0, Addr0, Wdata0,
        input  Req1, We1, Addr1, Wdata1,
        input  RamQ,
        output Gnt0, Rvalid0, Rdata0,
        output Gnt1, Rvalid1, Rdata1,
        output RamAddr, RamData, RamWren
    );

    modport master (
        output Req0, We0, Addr0, Wdata0,
        output Req1, We1, Addr1, Wdata1,
        output RamQ,
        input  Gnt0, Rvalid0, Rdata0,
        input  Gnt1, Rvalid1, Rdata1,
        input  RamAddr, RamData, RamWren
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter for a single-port RAM with tagged read return.
// Define RAM_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins).
module ram_port_arbiter #(
    parameter int AW     = 8,
    parameter int DW     = 16,
    parameter int RD_LAT = 1
) (
    input logic           Clk,
    input logic           Reset,
    ram_port_arbiter_if.slave bus
);
    localparam int PD = 1 + RD_LAT;

    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_any;
    logic          w_we;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;

    logic [AW-1:0] r_ram_addr;
    logic [DW-1:0] r_ram_data;
    logic          r_ram_wren;
    logic [PD-1:0] r_pv;
    logic [PD-1:0] r_po;

`ifdef RAM_ARB_FIXED_PRIO_EN
    always_comb begin
        w_gnt0 = !Reset && bus.Req0;
        w_gnt1 = !Reset && bus.Req1 && !bus.Req0;
    end
`else
    logic r_last;

    // On conflict the requester that did not win last time goes first.
    always_comb begin
        w_gnt0 = !Reset && bus.Req0 && (!bus.Req1 || r_last);
        w_gnt1 = !Reset && bus.Req1 && (!bus.Req0 || !r_last);
    end

    always_ff @(posedge Clk) begin
        if (Reset)
            r_last <= 1'b1;
        else if (w_gnt0)
            r_last <= 1'b0;
        else if (w_gnt1)
            r_last <= 1'b1;
    end
`endif

    always_comb begin
        w_any   = w_gnt0 | w_gnt1;
        w_we    = w_gnt0 ? bus.We0    : bus.We1;
        w_addr  = w_gnt0 ? bus.Addr0  : bus.Addr1;
        w_wdata = w_gnt0 ? bus.Wdata0 : bus.Wdata1;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_ram_addr <= '0;
            r_ram_data <= '0;
            r_ram_wren <= 1'b0;
        end else if (w_any) begin
            r_ram_addr <= w_addr;
            r_ram_data <= w_wdata;
            r_ram_wren <= w_we;
        end else begin
            r_ram_wren <= 1'b0;
        end
    end

    // Stage 0 is the issue register; the rest cover RAM read latency.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_pv <= '0;
            r_po <= '0;
        end else begin
            r_pv[0] <= w_any && !w_we;
            r_po[0] <= w_gnt1;
            for (int i = 1; i < PD; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_po[i] <= r_po[i-1];
            end
        end
    end

    assign bus.Gnt0    = w_gnt0;
    assign bus.Gnt1    = w_gnt1;
    assign bus.RamAddr = r_ram_addr;
    assign bus.RamData = r_ram_data;
    assign bus.RamWren = r_ram_wren;
    assign bus.Rvalid0 = r_pv[PD-1] && !r_po[PD-1];
    assign bus.Rvalid1 = r_pv[PD-1] &&  r_po[PD-1];
    assign bus.Rdata0  = bus.RamQ;
    assign bus.Rdata1  = bus.RamQ;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: behavioural RAM, reference memory and a
// read-return scoreboard checked on the falling edge.
module tb_ram_port_arbiter;
    localparam int AW = 8;
    localparam int DW = 16;

    typedef struct {
        bit            own;
        logic [DW-1:0] d;
        int            at;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    int            n_cmp = 0;
    int            n_err = 0;
    int            cyc = 0;
    logic [DW-1:0] mem [256];
    logic [DW-1:0] ref_mem [256];
    exp_t          sbq [$];

    ram_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    ram_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single-port RAM, one edge from capture to q.
    always @(posedge clk) begin
        if (bus.RamWren)
            mem[bus.RamAddr] <= bus.RamData;
        bus.RamQ <= mem[bus.RamAddr];
    end

    always @(negedge clk) begin
        if (bus.Rvalid0 || bus.Rvalid1) begin
            n_cmp++;
            if (bus.Rvalid0 && bus.Rvalid1) begin
                n_err++;
                $display("FAIL rvalid_both cyc=%0d got 1/1 want one", cyc);
            end else if (sbq.size() == 0) begin
                n_err++;
                $display("FAIL rvalid_spurious cyc=%0d rv0=%0b rv1=%0b want none",
                         cyc, bus.Rvalid0, bus.Rvalid1);
            end else begin
                exp_t e;
                logic [DW-1:0] d;
                e = sbq.pop_front();
                d = bus.Rvalid1 ? bus.Rdata1 : bus.Rdata0;
                if (bus.Rvalid1 !== e.own || d !== e.d || cyc !== e.at) begin
                    n_err++;
                    $display("FAIL rdata cyc=%0d own=%0b data=%0d got; want cyc=%0d own=%0b data=%0d",
                             cyc, bus.Rvalid1, d, e.at, e.own, e.d);
                end
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.Req0 = 1'b0;
        bus.Req1 = 1'b0;
    endtask

    task automatic drv(input bit p, input bit we, input int a, input int d);
        if (p) begin
            bus.Req1 = 1'b1; bus.We1 = we;
            bus.Addr1 = AW'(a); bus.Wdata1 = DW'(d);
        end else begin
            bus.Req0 = 1'b1; bus.We0 = we;
            bus.Addr0 = AW'(a); bus.Wdata0 = DW'(d);
        end
        #1;
    endtask

    // Record the bench-expected winner of this cycle in the reference model.
    task automatic issue(input bit p);
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        exp_t          e;
        we = p ? bus.We1 : bus.We0;
        a  = p ? bus.Addr1 : bus.Addr0;
        d  = p ? bus.Wdata1 : bus.Wdata0;
        if (we) begin
            ref_mem[a] = d;
        end else begin
            e.own = p;
            e.d   = ref_mem[a];
            e.at  = cyc + 2;
            sbq.push_back(e);
        end
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 8 && sbq.size() != 0; i++)
            next();
        n_cmp++;
        if (sbq.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain pending=%0d want 0", nm, sbq.size());
            sbq.delete();
        end
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        next();
        next();
        drv(0, 1'b1, 3, 3);
        drv(1, 1'b1, 4, 4);
        n_cmp++;
        if ({bus.Gnt0, bus.Gnt1} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_gnt got %b want 00", {bus.Gnt0, bus.Gnt1});
        end
        n_cmp++;
        if ({bus.RamWren, bus.RamAddr, bus.RamData} !== '0) begin
            n_err++;
            $display("FAIL reset_ram got wren=%0b addr=%0d data=%0d want 0/0/0",
                     bus.RamWren, bus.RamAddr, bus.RamData);
        end
        n_cmp++;
        if ({bus.Rvalid0, bus.Rvalid1} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_rvalid got %b want 00", {bus.Rvalid0, bus.Rvalid1});
        end
        idle();
        next();
        rst = 1'b0;
    endtask

    task automatic test_single();
        drv(0, 1'b1, 5, 10);
        n_cmp++;
        if ({bus.Gnt0, bus.Gnt1} !== 2'b10) begin
            n_err++;
            $display("FAIL single_wr_gnt got %b want 10", {bus.Gnt0, bus.Gnt1});
        end
        issue(0);
        next();
        n_cmp++;
        if ({bus.RamWren, bus.RamAddr, bus.RamData} !== {1'b1, 8'd5, 16'd10}) begin
            n_err++;
            $display("FAIL single_issue got wren=%0b addr=%0d data=%0d want 1/5/10",
                     bus.RamWren, bus.RamAddr, bus.RamData);
        end
        drv(0, 1'b0, 5, 0);
        n_cmp++;
        if (bus.Gnt0 !== 1'b1) begin
            n_err++;
            $display("FAIL single_rd_gnt got %b want 1", bus.Gnt0);
        end
        issue(0);
        next();
        idle();
        next();
        n_cmp++;
        if (bus.RamWren !== 1'b0 || bus.RamAddr !== 8'd5) begin
            n_err++;
            $display("FAIL single_idle got wren=%0b addr=%0d want 0/5",
                     bus.RamWren, bus.RamAddr);
        end
        drain("single");
    endtask

    task automatic test_back_to_back();
        bit [DW-1:0] wd [5] = '{20, 0, 0, 30, 0};
        bit [AW-1:0] ad [5] = '{41, 5, 41, 41, 41};
        bit          wv [5] = '{1, 0, 0, 1, 0};
        for (int i = 0; i < 5; i++) begin
            drv(0, wv[i], int'(ad[i]), int'(wd[i]));
            n_cmp++;
            if (bus.Gnt0 !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_gnt[%0d] got %b want 1", i, bus.Gnt0);
            end
            issue(0);
            next();
        end
        idle();
        drain("b2b");
    endtask

    task automatic test_contention(input int n, input string nm);
        bit p;
        rst = 1'b1;
        idle();
        next();
        rst = 1'b0;
        drv(0, 1'b0, 5, 0);
        drv(1, 1'b0, 41, 0);
        for (int i = 0; i < n; i++) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
            p = 1'b0;
`else
            p = (i % 2) == 1;
`endif
            n_cmp++;
            if ({bus.Gnt0, bus.Gnt1} !== {!p, p}) begin
                n_err++;
                $display("FAIL %s_gnt[%0d] got %b want %b", nm, i,
                         {bus.Gnt0, bus.Gnt1}, {!p, p});
            end
            issue(p);
            next();
        end
        idle();
        drain(nm);
    endtask

    task automatic test_cross_raw();
        drv(1, 1'b1, 7, 99);
        n_cmp++;
        if ({bus.Gnt0, bus.Gnt1} !== 2'b01) begin
            n_err++;
            $display("FAIL raw_wr_gnt got %b want 01", {bus.Gnt0, bus.Gnt1});
        end
        issue(1);
        next();
        idle();
        drv(0, 1'b0, 7, 0);
        n_cmp++;
        if (bus.Gnt0 !== 1'b1) begin
            n_err++;
            $display("FAIL raw_rd_gnt got %b want 1", bus.Gnt0);
        end
        issue(0);
        next();
        idle();
        drain("raw");
    endtask

    task automatic test_reset_mid();
        drv(0, 1'b0, 41, 0);
        issue(0);
        next();
        rst = 1'b1;
        sbq.delete();
        drv(1, 1'b1, 9, 9);
        n_cmp++;
        if ({bus.Gnt0, bus.Gnt1} !== 2'b00) begin
            n_err++;
            $display("FAIL rstmid_gnt got %b want 00", {bus.Gnt0, bus.Gnt1});
        end
        next();
        n_cmp++;
        if (bus.RamWren !== 1'b0 || bus.Rvalid0 !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_state got wren=%0b rv0=%0b want 0/0",
                     bus.RamWren, bus.Rvalid0);
        end
        idle();
        next();
        rst = 1'b0;
        next();
        drv(0, 1'b0, 5, 0);
        n_cmp++;
        if (bus.Gnt0 !== 1'b1 || ref_mem[5] !== 16'd10) begin
            n_err++;
            $display("FAIL rstmid_rd gnt=%b ref=%0d want 1/10", bus.Gnt0, ref_mem[5]);
        end
        issue(0);
        next();
        idle();
        drain("rstmid");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d want finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        bus.We0 = 1'b0; bus.Addr0 = '0; bus.Wdata0 = '0;
        bus.We1 = 1'b0; bus.Addr1 = '0; bus.Wdata1 = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_contention(4, "rr4");
        test_cross_raw();
        test_reset_mid();
        test_contention(5, "cont5");
        next();
        next();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
